regfile_fwd: RTL and testbench

Parametrised general-purpose register file for the experiment CPU datapath. It generalises the 4x8 single-read-port register file:
- WIDTH and DEPTH are configurable.
- Two registered read ports with write-through forwarding.
- Independent external-load and ALU-writeback write ports with fixed priority.
- A per-register busy scoreboard that blocks external loads into registers awaiting an ALU result.

It sits between the instruction decoder/ALU and the panel data switches.

---
 rtl/regfile_fwd.sv | 117 +++++++++++
 tb/tb_regfile_fwd.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_fwd.sv
// Parameterised register file: two write ports (ALU writeback wins over load), two reads, busy scoreboard.
// Reads and all state update on the falling clock edge and read data appears one edge later; a rejected load raises ld_drop, with no other backpressure.
module regfile_fwd #(
    parameter int                WIDTH     = 8,
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_W-1:0]       rd_addr_a,
    input  logic [ADDR_W-1:0]       rd_addr_b,
    output logic [WIDTH-1:0]        x_a,
    output logic [WIDTH-1:0]        x_b,
    input  logic                    ld_en,
    input  logic [ADDR_W-1:0]       ld_addr,
    input  logic [WIDTH-1:0]        ld_data,
    input  logic                    wb_en,
    input  logic [ADDR_W-1:0]       wb_addr,
    input  logic [WIDTH-1:0]        wb_data,
    input  logic                    iss_en,
    input  logic [ADDR_W-1:0]       iss_dest,
    output logic [DEPTH-1:0]        busy,
    output logic                    ld_drop,
    output logic [WIDTH*DEPTH-1:0]  regs_flat
);

    localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_A;
    endfunction

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] x_a_q, x_a_d;
    logic [WIDTH-1:0] x_b_q, x_b_d;
    logic [DEPTH-1:0] busy_q, busy_d;
    logic             ld_drop_q, ld_drop_d;

    logic ld_req;
    logic wb_hit;
    logic ld_busy;
    logic ld_acc;

    always_comb begin
        ld_req  = ld_en & in_range(ld_addr);
        wb_hit  = wb_en & in_range(wb_addr);
        ld_busy = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ld_addr == ADDR_W'(i)) begin
                ld_busy = busy_q[i];
            end
        end
        // busy is the pre-edge value, so a load racing a clearing writeback still drops
        ld_acc    = ld_req & ~ld_busy & ~(wb_en & (wb_addr == ld_addr));
        ld_drop_d = ld_req & ~ld_acc;

        for (int i = 0; i < DEPTH; i++) begin
            regs_d[i] = regs_q[i];
            if (ld_acc && ld_addr == ADDR_W'(i)) begin
                regs_d[i] = ld_data;
            end
            if (wb_hit && wb_addr == ADDR_W'(i)) begin
                regs_d[i] = wb_data;
            end
            busy_d[i] = busy_q[i];
            if (iss_en && iss_dest == ADDR_W'(i)) begin
                busy_d[i] = 1'b1;
            end else if (wb_en && wb_addr == ADDR_W'(i)) begin
                busy_d[i] = 1'b0;
            end
        end

        // read the next-state array so same-edge writes forward straight through
        x_a_d = '0;
        x_b_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_addr_a == ADDR_W'(i)) begin
                x_a_d = regs_d[i];
            end
            if (rd_addr_b == ADDR_W'(i)) begin
                x_b_d = regs_d[i];
            end
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= RESET_VAL;
            end
            x_a_q     <= RESET_VAL;
            x_b_q     <= RESET_VAL;
            busy_q    <= '0;
            ld_drop_q <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
            x_a_q     <= x_a_d;
            x_b_q     <= x_b_d;
            busy_q    <= busy_d;
            ld_drop_q <= ld_drop_d;
        end
    end

    assign x_a     = x_a_q;
    assign x_b     = x_b_q;
    assign busy    = busy_q;
    assign ld_drop = ld_drop_q;

    for (genvar g = 0; g < DEPTH; g++) begin : g_flat
        assign regs_flat[g*WIDTH +: WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed bench for regfile_fwd: default 4x8 instance plus a 6x16 instance with out-of-range addresses.
module tb_regfile_fwd;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // default instance
    logic [1:0]  rd_addr_a, rd_addr_b, ld_addr, wb_addr, iss_dest;
    logic [7:0]  x_a, x_b, ld_data, wb_data;
    logic        ld_en, wb_en, iss_en, ld_drop;
    logic [3:0]  busy;
    logic [31:0] regs_flat;

    // wide instance: DEPTH=6 with a 3-bit address, so 6 and 7 are out of range
    logic [2:0]  rd_a2, rd_b2, ld_addr2, wb_addr2, iss_dest2;
    logic [15:0] x_a2, x_b2, ld_data2, wb_data2;
    logic        ld_en2, wb_en2, iss_en2, ld_drop2;
    logic [5:0]  busy2;
    logic [95:0] regs_flat2;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_q[$];

    regfile_fwd dut (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .x_a(x_a), .x_b(x_b),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .iss_en(iss_en), .iss_dest(iss_dest),
        .busy(busy), .ld_drop(ld_drop), .regs_flat(regs_flat)
    );

    regfile_fwd #(.WIDTH(16), .DEPTH(6), .ADDR_W(3), .RESET_VAL(16'h1234)) dut2 (
        .clk(clk), .rst(rst),
        .rd_addr_a(rd_a2), .rd_addr_b(rd_b2), .x_a(x_a2), .x_b(x_b2),
        .ld_en(ld_en2), .ld_addr(ld_addr2), .ld_data(ld_data2),
        .wb_en(wb_en2), .wb_addr(wb_addr2), .wb_data(wb_data2),
        .iss_en(iss_en2), .iss_dest(iss_dest2),
        .busy(busy2), .ld_drop(ld_drop2), .regs_flat(regs_flat2)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [127:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [127:0] obs);
        logic [127:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0h but no expected value queued", tag, obs);
            return;
        end
        e = exp_q.pop_front();
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
        end
    endtask

    task automatic idle();
        ld_en = 0; wb_en = 0; iss_en = 0;
        ld_addr = 0; wb_addr = 0; iss_dest = 0; ld_data = 0; wb_data = 0;
        ld_en2 = 0; wb_en2 = 0; iss_en2 = 0;
        ld_addr2 = 0; wb_addr2 = 0; iss_dest2 = 0; ld_data2 = 0; wb_data2 = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle();
        rst = 1; rd_addr_a = 0; rd_addr_b = 3; rd_a2 = 0; rd_b2 = 7;

        // reset for two edges
        push(0); push(0); push(0); push(0); push(0);
        push(16'h1234); push(16'h1234); push(0); push({6{16'h1234}});
        tick(); tick();
        chk("rst_x_a", x_a); chk("rst_x_b", x_b); chk("rst_busy", busy);
        chk("rst_flat", regs_flat); chk("rst_drop", ld_drop);
        chk("rst2_x_a", x_a2); chk("rst2_x_b", x_b2); chk("rst2_busy", busy2);
        chk("rst2_flat", regs_flat2);

        // load with write-through; wide instance loads top register and reads out of range
        rst = 0;
        ld_en = 1; ld_addr = 2; ld_data = 8'hA5; rd_addr_a = 2; rd_addr_b = 1;
        ld_en2 = 1; ld_addr2 = 5; ld_data2 = 16'hBEEF; rd_a2 = 5; rd_b2 = 7;
        push(8'hA5); push(0); push(32'h00A50000); push(0);
        push(16'hBEEF); push(0); push(16'hBEEF); push(0);
        tick();
        chk("ld_wt_x_a", x_a); chk("ld_wt_x_b", x_b); chk("ld_wt_flat", regs_flat);
        chk("ld_wt_drop", ld_drop);
        chk("w_ld_x_a", x_a2); chk("w_ld_x_b_oor", x_b2); chk("w_ld_top", regs_flat2[95:80]);
        chk("w_ld_drop", ld_drop2);

        // write conflict: writeback wins; wide instance: out-of-range load/issue/writeback ignored
        idle();
        ld_en = 1; ld_addr = 1; ld_data = 8'h11;
        wb_en = 1; wb_addr = 1; wb_data = 8'h77; rd_addr_a = 1; rd_addr_b = 1;
        ld_en2 = 1; ld_addr2 = 6; ld_data2 = 16'h1111; iss_en2 = 1; iss_dest2 = 7;
        wb_en2 = 1; wb_addr2 = 6; wb_data2 = 16'h2222; rd_a2 = 6; rd_b2 = 0;
        push(8'h77); push(8'h77); push(1); push(32'h00A57700);
        push(0); push(16'h1234); push(0); push(0); push({16'hBEEF, {5{16'h1234}}});
        tick();
        chk("cf_x_a", x_a); chk("cf_x_b", x_b); chk("cf_drop", ld_drop); chk("cf_flat", regs_flat);
        chk("w_oor_x_a", x_a2); chk("w_oor_x_b", x_b2); chk("w_oor_drop", ld_drop2);
        chk("w_oor_busy", busy2); chk("w_oor_flat", regs_flat2);

        idle();
        push(0);
        tick();
        chk("cf_drop_clr", ld_drop);

        // scoreboard blocks a load into a busy register
        iss_en = 1; iss_dest = 3;
        push(4'b1000);
        tick();
        chk("sb_busy_set", busy);

        idle();
        ld_en = 1; ld_addr = 3; ld_data = 8'h55; rd_addr_a = 3;
        push(4'b1000); push(0); push(1); push(32'h00A57700);
        tick();
        chk("sb_busy_hold", busy); chk("sb_x_a", x_a); chk("sb_drop", ld_drop);
        chk("sb_flat", regs_flat);

        idle();
        wb_en = 1; wb_addr = 3; wb_data = 8'h3C; rd_addr_b = 3;
        push(0); push(8'h3C); push(0); push(32'h3CA57700);
        tick();
        chk("sb_busy_clr", busy); chk("sb_x_b", x_b); chk("sb_drop_clr", ld_drop);
        chk("sb_wb_flat", regs_flat);

        // simultaneous issue and writeback keeps the register busy
        idle();
        iss_en = 1; iss_dest = 0;
        push(4'b0001);
        tick();
        chk("sim_busy_pre", busy);

        iss_en = 1; iss_dest = 0; wb_en = 1; wb_addr = 0; wb_data = 8'h09; rd_addr_a = 0;
        push(4'b0001); push(8'h09); push(32'h3CA57709);
        tick();
        chk("sim_busy", busy); chk("sim_x_a", x_a); chk("sim_flat", regs_flat);

        // build busy=1010, with a dropped load on the last edge before reset
        idle();
        iss_en = 1; iss_dest = 1; wb_en = 1; wb_addr = 0; wb_data = 8'h42;
        push(4'b0010);
        tick();
        chk("pre_busy0", busy);

        idle();
        iss_en = 1; iss_dest = 3; ld_en = 1; ld_addr = 1; ld_data = 8'hEE;
        push(4'b1010); push(1); push(32'h3CA57742);
        tick();
        chk("pre_busy", busy); chk("pre_drop", ld_drop); chk("pre_flat", regs_flat);

        // reset mid-operation with in-flight writes and a would-be dropped load
        idle();
        rst = 1; wb_en = 1; wb_addr = 2; wb_data = 8'hFF; ld_en = 1; ld_addr = 3; ld_data = 8'h5A;
        rd_addr_a = 2; rd_addr_b = 2;
        push(0); push(0); push(0); push(0); push(0); push({6{16'h1234}});
        tick();
        chk("mid_flat", regs_flat); chk("mid_busy", busy); chk("mid_x_a", x_a);
        chk("mid_x_b", x_b); chk("mid_drop", ld_drop); chk("mid2_flat", regs_flat2);

        idle();
        rst = 0;
        push(0); push(0); push(0);
        tick();
        chk("post_drop", ld_drop); chk("post_busy", busy); chk("post_flat", regs_flat);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover: %0d expected values never compared, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
